// File: rtl/next_pc_predictor.sv
// rtl/next_pc_predictor.sv - next-PC selection with a direct-mapped BTB and 2-bit counters
module next_pc_predictor #(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] current_pc_count,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  output logic [31:0] next_pc_count,
  output logic        predict_taken,
  output logic [31:0] predict_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0]             btb_valid;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0]  btb_tag;
  logic [BTB_ENTRIES-1:0][31:0]       btb_target;
  logic [BTB_ENTRIES-1:0][1:0]        btb_ctr;

  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic             lookup_hit;
  logic [IDX_W-1:0] train_idx;
  logic [TAG_W-1:0] train_tag;
  logic             train_hit;
  logic             unused_low_bits;

  // Word alignment is assumed; the byte-offset bits never reach the table.
  assign unused_low_bits = ^{current_pc_count[1:0], resolve_pc[1:0]};

  assign lookup_idx = current_pc_count[IDX_W+1:2];
  assign lookup_tag = current_pc_count[31:IDX_W+2];
  assign lookup_hit = btb_valid[lookup_idx] && (btb_tag[lookup_idx] == lookup_tag);

  assign predict_taken  = lookup_hit && btb_ctr[lookup_idx][1];
  assign predict_target = predict_taken ? btb_target[lookup_idx] : 32'h0;

  always_comb begin
    next_pc_count = current_pc_count + 32'd4;
    if (halt)
      next_pc_count = current_pc_count;
    else if (redirect_valid)
      next_pc_count = redirect_pc;
    else if (predict_taken)
      next_pc_count = predict_target;
  end

  assign train_idx = resolve_pc[IDX_W+1:2];
  assign train_tag = resolve_pc[31:IDX_W+2];
  assign train_hit = btb_valid[train_idx] && (btb_tag[train_idx] == train_tag);

  // Training ignores halt/redirect so that older branches still retire into the table.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      btb_valid  <= '0;
      btb_tag    <= '0;
      btb_target <= '0;
      btb_ctr    <= '0;
    end else if (resolve_valid) begin
      if (train_hit) begin
        if (resolve_taken) begin
          btb_target[train_idx] <= resolve_target;
          if (btb_ctr[train_idx] != 2'b11)
            btb_ctr[train_idx] <= btb_ctr[train_idx] + 2'd1;
        end else if (btb_ctr[train_idx] != 2'b00) begin
          btb_ctr[train_idx] <= btb_ctr[train_idx] - 2'd1;
        end
      end else if (resolve_taken) begin
        btb_valid[train_idx]  <= 1'b1;
        btb_tag[train_idx]    <= train_tag;
        btb_target[train_idx] <= resolve_target;
        btb_ctr[train_idx]    <= 2'b10;
      end
    end
  end

endmodule
